// File: rtl/hazard_tracker_pkg.sv
// hazard_tracker_pkg: register-index width, x0 constant and pipeline shadow-entry layouts
package hazard_tracker_pkg;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_idx_t;
  localparam reg_idx_t X0 = '0;
  typedef struct packed {
    logic     valid;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     regwrite;
    logic     memread;
  } ex_entry_t;
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regwrite;
  } mem_entry_t;
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regwrite;
  } wb_entry_t;
  typedef enum logic [1:0] {ADVANCE, LOAD_USE, FLUSH, BUSY} action_e;
  function automatic logic reads(input logic used, input reg_idx_t src, input reg_idx_t rd);
    return used && src == rd;
  endfunction
endpackage

// File: rtl/hazard_tracker_stage_reg.sv
// hazard_stage_reg: one shadow pipeline entry; valid is the MSB, bubble clears only valid
module hazard_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;
  always_comb q_d = hold ? q_q : bubble ? {1'b0, q_q[W-2:0]} : d;
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: load-use / flush / memory-busy hazard control with forwarding operands
module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  input  logic        mem_busy,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        flush_ifid,
  output logic        bubble_idex,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  ex_mem_rd,
  output logic [4:0]  mem_wb_rd,
  output logic        ex_mem_regwrite,
  output logic        mem_wb_regwrite,
  output logic [31:0] stall_cycles
);
  ex_entry_t  ex_d, ex_q;
  mem_entry_t mem_d, mem_q;
  wb_entry_t  wb_d, wb_q;
  action_e    act;
  logic       load_use;
  logic [31:0] stall_cycles_d, stall_cycles_q;
  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.memread && ex_q.regwrite && ex_q.rd != X0 &&
               (reads(id_rs1_used, id_rs1, ex_q.rd) || reads(id_rs2_used, id_rs2, ex_q.rd));
    act = mem_busy ? BUSY : flush ? FLUSH : load_use ? LOAD_USE : ADVANCE;
    ex_d = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
             regwrite: id_regwrite, memread: id_memread};
    mem_d = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
    wb_d = '{valid: mem_q.valid, rd: mem_q.rd, regwrite: mem_q.regwrite};
    // controls are masked while reset is asserted so nothing leaks out of a discarded stall
    stall_pc = !cpu_rst && (act == BUSY || act == LOAD_USE);
    stall_ifid = stall_pc;
    flush_ifid = !cpu_rst && act == FLUSH;
    bubble_idex = !cpu_rst && (act == FLUSH || act == LOAD_USE);
    stall_cycles_d = (stall_pc && stall_cycles_q != 32'hFFFF_FFFF) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end
  hazard_stage_reg #(.W($bits(ex_entry_t))) u_ex (
    .clk(cpu_clk), .rst(cpu_rst), .hold(act == BUSY),
    .bubble(act == FLUSH || act == LOAD_USE), .d(ex_d), .q(ex_q)
  );
  hazard_stage_reg #(.W($bits(mem_entry_t))) u_mem (
    .clk(cpu_clk), .rst(cpu_rst), .hold(act == BUSY), .bubble(1'b0), .d(mem_d), .q(mem_q)
  );
  hazard_stage_reg #(.W($bits(wb_entry_t))) u_wb (
    .clk(cpu_clk), .rst(cpu_rst), .hold(act == BUSY), .bubble(1'b0), .d(wb_d), .q(wb_q)
  );
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) stall_cycles_q <= '0;
    else stall_cycles_q <= stall_cycles_d;
  end
  assign id_ex_rs1 = ex_q.rs1;
  assign id_ex_rs2 = ex_q.rs2;
  assign ex_mem_rd = mem_q.rd;
  assign mem_wb_rd = wb_q.rd;
  assign ex_mem_regwrite = !cpu_rst && mem_q.valid && mem_q.regwrite;
  assign mem_wb_regwrite = !cpu_rst && wb_q.valid && wb_q.regwrite;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: table-driven hazard sequences checked through an expected-result queue
module tb_hazard_tracker;
  logic cpu_clk = 1'b0;
  logic cpu_rst, id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, flush, mem_busy;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic stall_pc, stall_ifid, flush_ifid, bubble_idex, ex_mem_regwrite, mem_wb_regwrite;
  logic [4:0] id_ex_rs1, id_ex_rs2, ex_mem_rd, mem_wb_rd;
  logic [31:0] stall_cycles;
  typedef struct packed {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic [4:0] rd;
    logic rw; logic mr; logic fl; logic bz; logic rst;
  } in_t;
  typedef struct packed {
    logic [3:0] ctl; logic [4:0] emrd; logic emrw; logic [4:0] mwrd; logic mwrw;
    logic [4:0] idrs1; logic [31:0] cyc;
  } exp_t;
  typedef struct { in_t i; exp_t e; } vec_t;
  vec_t tbl[22];
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  hazard_tracker dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite), .stall_cycles(stall_cycles)
  );
  always #5 cpu_clk = ~cpu_clk;
  function automatic in_t mk_in(input int v, rs1, rs2, u1, u2, rd, rw, mr, fl, bz, rst);
    in_t r;
    r.v = 1'(v); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = 1'(u1); r.u2 = 1'(u2); r.rd = 5'(rd);
    r.rw = 1'(rw); r.mr = 1'(mr); r.fl = 1'(fl); r.bz = 1'(bz); r.rst = 1'(rst);
    return r;
  endfunction
  function automatic exp_t mk_exp(input int ctl, emrd, emrw, mwrd, mwrw, idrs1, input logic [31:0] cyc);
    exp_t r;
    r.ctl = 4'(ctl); r.emrd = 5'(emrd); r.emrw = 1'(emrw); r.mwrd = 5'(mwrd); r.mwrw = 1'(mwrw);
    r.idrs1 = 5'(idrs1); r.cyc = cyc;
    return r;
  endfunction
  task automatic drive(input in_t i);
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rs1_used = i.u1; id_rs2_used = i.u2;
    id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr; flush = i.fl; mem_busy = i.bz; cpu_rst = i.rst;
  endtask
  task automatic cmp(input string tag, input int step, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] %s: got 0x%0h, expected 0x%0h", tag, step, nm, act, exp);
    end
  endtask
  task automatic apply(input string tag, input int step, input in_t i, input exp_t e);
    exp_t x;
    @(negedge cpu_clk);
    drive(i);
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s[%0d] scoreboard: got empty queue, expected one entry", tag, step);
    end else begin
      x = sb.pop_front();
      cmp(tag, step, "ctl", {28'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex}, {28'd0, x.ctl});
      cmp(tag, step, "fwd", {20'd0, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite},
          {20'd0, x.emrd, x.emrw, x.mwrd, x.mwrw});
      cmp(tag, step, "id_ex_rs1", {27'd0, id_ex_rs1}, {27'd0, x.idrs1});
      cmp(tag, step, "stall_cycles", stall_cycles, x.cyc);
    end
  endtask
  initial begin
    in_t nop, busy, lw5, dep5, dep5f;
    nop  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    busy = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lw5  = mk_in(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    dep5 = mk_in(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
    dep5f = mk_in(1, 5, 1, 1, 1, 6, 1, 0, 1, 0, 0);
    // lw x5 -> dependent, lw x0, flush vs. load-use, busy freeze, rs2 load-use, unused source
    tbl[0]  = '{nop, mk_exp(0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{lw5, mk_exp(0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{dep5, mk_exp(4'b1101, 0, 0, 0, 0, 2, 0)};
    tbl[3]  = '{dep5, mk_exp(0, 5, 1, 0, 0, 2, 1)};
    tbl[4]  = '{nop, mk_exp(0, 5, 0, 5, 1, 5, 1)};
    tbl[5]  = '{mk_in(1, 3, 0, 1, 0, 0, 1, 1, 0, 0, 0), mk_exp(0, 6, 1, 5, 0, 0, 1)};
    tbl[6]  = '{mk_in(1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0), mk_exp(0, 0, 0, 6, 1, 3, 1)};
    tbl[7]  = '{lw5, mk_exp(0, 0, 1, 0, 0, 0, 1)};
    tbl[8]  = '{dep5f, mk_exp(4'b0011, 6, 1, 0, 1, 2, 1)};
    tbl[9]  = '{nop, mk_exp(0, 5, 1, 6, 1, 2, 1)};
    tbl[10] = '{mk_in(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0), mk_exp(0, 5, 0, 5, 1, 0, 1)};
    tbl[11] = '{nop, mk_exp(0, 0, 0, 5, 0, 1, 1)};
    tbl[12] = '{busy, mk_exp(4'b1100, 7, 1, 0, 0, 0, 1)};
    tbl[13] = '{busy, mk_exp(4'b1100, 7, 1, 0, 0, 0, 2)};
    tbl[14] = '{busy, mk_exp(4'b1100, 7, 1, 0, 0, 0, 3)};
    tbl[15] = '{nop, mk_exp(0, 7, 1, 0, 0, 0, 4)};
    tbl[16] = '{mk_in(1, 2, 0, 1, 0, 9, 1, 1, 0, 0, 0), mk_exp(0, 0, 0, 7, 1, 0, 4)};
    tbl[17] = '{mk_in(1, 9, 3, 0, 1, 4, 1, 0, 0, 0, 0), mk_exp(0, 0, 0, 0, 0, 2, 4)};
    tbl[18] = '{mk_in(1, 2, 0, 1, 0, 9, 1, 1, 0, 0, 0), mk_exp(0, 9, 1, 0, 0, 9, 4)};
    tbl[19] = '{mk_in(1, 1, 9, 1, 1, 10, 1, 0, 0, 0, 0), mk_exp(4'b1101, 4, 1, 9, 1, 2, 4)};
    tbl[20] = '{mk_in(1, 1, 9, 1, 1, 10, 1, 0, 0, 0, 0), mk_exp(0, 9, 1, 4, 1, 2, 5)};
    tbl[21] = '{nop, mk_exp(0, 9, 0, 9, 1, 1, 5)};
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    @(posedge cpu_clk);
    apply("reset", 0, mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), mk_exp(0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 22; k++) apply("tbl", k, tbl[k].i, tbl[k].e);
    apply("rst_stall", 0, lw5, mk_exp(0, 10, 1, 9, 0, 0, 5));
    apply("rst_stall", 1, mk_in(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1), mk_exp(0, 0, 0, 10, 0, 2, 5));
    apply("rst_stall", 2, dep5, mk_exp(0, 0, 0, 0, 0, 0, 0));
    @(posedge cpu_clk);
    #1 force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cycles_q;
    apply("sat", 0, busy, mk_exp(4'b1100, 0, 0, 0, 0, 5, 32'hFFFF_FFFE));
    apply("sat", 1, busy, mk_exp(4'b1100, 0, 0, 0, 0, 5, 32'hFFFF_FFFF));
    apply("sat", 2, busy, mk_exp(4'b1100, 0, 0, 0, 0, 5, 32'hFFFF_FFFF));
    apply("sat", 3, nop, mk_exp(0, 0, 0, 0, 0, 5, 32'hFFFF_FFFF));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
